// File: rtl/chacha_pkg.sv
// Shared constants, index tables, FSM encoding and parameter checks for the
// ChaCha block-function engine.
package chacha_pkg;

  localparam logic [31:0] SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};

  localparam logic [31:0] IN_RESET [16] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  // Word indices (a,b,c,d) of each quarter-round in a column / diagonal round.
  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] DIAG_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_RUN   = 2'd1,
    CS_FINAL = 2'd2
  } chacha_state_e;

  function automatic bit chacha_cfg_ok(input int rounds, input int qr_per_cycle);
    bit ok;
    ok = (rounds >= 2) && (rounds <= 20) && ((rounds % 2) == 0);
    ok = ok && ((qr_per_cycle == 1) || (qr_per_cycle == 4));
    return ok;
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// Standard ChaCha quarter-round, purely combinational.
module chacha_quarter_round
  import chacha_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  logic [31:0] a1_s, b1_s, c1_s, d1_s;

  assign a1_s = a_i + b_i;
  assign d1_s = rotl32(d_i ^ a1_s, 16);
  assign c1_s = c_i + d1_s;
  assign b1_s = rotl32(b_i ^ c1_s, 12);

  assign a_o  = a1_s + b1_s;
  assign d_o  = rotl32(d1_s ^ a_o, 8);
  assign c_o  = c1_s + d_o;
  assign b_o  = rotl32(b1_s ^ c_o, 7);

endmodule

// File: rtl/chacha_block_engine.sv
// ChaCha block-function engine: loadable input state, iterated rounds with
// 1 or 4 quarter-round lanes, feed-forward and a registered output read port.
module chacha_block_engine
  import chacha_pkg::*;
#(
  parameter int ROUNDS       = 20,
  parameter int QR_PER_CYCLE = 1,
  parameter int AUTO_INC     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [7:0]  round_count
);

  localparam int              LANES     = QR_PER_CYCLE;
  localparam int              N_STEPS   = ROUNDS * 4 / QR_PER_CYCLE;
  localparam logic [7:0]      LAST_STEP = 8'(N_STEPS - 1);
  localparam logic [1:0]      S_IDLE    = 2'(CS_IDLE);
  localparam logic [1:0]      S_RUN     = 2'(CS_RUN);
  localparam logic [1:0]      S_FINAL   = 2'(CS_FINAL);

  if (!chacha_cfg_ok(ROUNDS, QR_PER_CYCLE)) begin : g_cfg_check
    $error("chacha_block_engine: illegal ROUNDS/QR_PER_CYCLE");
  end

  logic [1:0]  state_q, state_d;
  logic [7:0]  step_q, step_d;
  logic [7:0]  round_q, round_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rd_data_q;
  logic [31:0] in_q  [16];
  logic [31:0] in_d  [16];
  logic [31:0] w_q   [16];
  logic [31:0] w_d   [16];
  logic [31:0] out_q [16];
  logic [31:0] out_d [16];

  logic        odd_s;
  logic        round_done_s;
  logic [3:0]  idx_s  [LANES][4];
  logic [31:0] qin_s  [LANES][4];
  logic [31:0] qout_s [LANES][4];
  logic [31:0] w_next_s [16];

  // Single-lane mode walks the QRs of a round via step[1:0]; four lanes cover a round at once.
  always_comb begin
    logic [1:0] qsel;
    qsel = 2'd0;
    if (QR_PER_CYCLE == 1) begin
      odd_s        = step_q[2];
      round_done_s = (step_q[1:0] == 2'd3);
    end else begin
      odd_s        = step_q[0];
      round_done_s = 1'b1;
    end
    for (int l = 0; l < LANES; l++) begin
      if (QR_PER_CYCLE == 1) qsel = step_q[1:0];
      else                   qsel = 2'(l);
      for (int j = 0; j < 4; j++) begin
        if (odd_s) idx_s[l][j] = DIAG_IDX[qsel][j];
        else       idx_s[l][j] = COL_IDX[qsel][j];
        qin_s[l][j] = w_q[idx_s[l][j]];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    chacha_quarter_round u_qr (
      .a_i (qin_s[l][0]), .b_i (qin_s[l][1]), .c_i (qin_s[l][2]), .d_i (qin_s[l][3]),
      .a_o (qout_s[l][0]), .b_o (qout_s[l][1]), .c_o (qout_s[l][2]), .d_o (qout_s[l][3])
    );
  end

  always_comb begin
    w_next_s = w_q;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < 4; j++) begin
        w_next_s[idx_s[l][j]] = qout_s[l][j];
      end
    end
  end

  // A start in the same cycle as a write snapshots the pre-write input state.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    in_d    = in_q;
    w_d     = w_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (wr_en) in_d[wr_addr] = wr_data;
        else       in_d = in_q;
        if (start) begin
          w_d     = in_q;
          step_d  = 8'd0;
          round_d = 8'd0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        w_d    = w_next_s;
        step_d = step_q + 8'd1;
        if (round_done_s) round_d = round_q + 8'd1;
        else              round_d = round_q;
        if (step_q == LAST_STEP) state_d = S_FINAL;
        else                     state_d = S_RUN;
      end
      S_FINAL: begin
        for (int i = 0; i < 16; i++) out_d[i] = w_q[i] + in_q[i];
        if (AUTO_INC != 0) in_d[12] = in_q[12] + 32'd1;
        else               in_d[12] = in_q[12];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 8'd0;
      round_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      in_q    <= IN_RESET;
      w_q     <= '{default: 32'd0};
      out_q   <= '{default: 32'd0};
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      in_q    <= in_d;
      w_q     <= w_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= 32'd0;
    else        rd_data_q <= out_q[rd_addr];
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_data     = rd_data_q;
  assign round_count = round_q;

endmodule

// File: tb/tb_chacha_block_engine.sv
// Directed bench for chacha_block_engine: QR unit vector, RFC 8439 block,
// counter wrap, back-to-back start, busy-time pokes and mid-run reset.
module tb_chacha_block_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic [3:0]  rd_addr;
  logic        busy1, done1, busy4, done4;
  logic [31:0] rd_data1, rd_data4;
  logic [7:0]  round_count1, round_count4;
  logic [31:0] qa, qb, qc, qd, ra, rb, rc, rd;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] shadow  [16];
  logic [31:0] mdl_w   [16];
  logic [31:0] mdl_out [16];

  always #5 clk = ~clk;

  chacha_block_engine dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy1), .done(done1), .rd_addr(rd_addr), .rd_data(rd_data1),
    .round_count(round_count1)
  );

  chacha_block_engine #(.QR_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy4), .done(done4), .rd_addr(rd_addr), .rd_data(rd_data4),
    .round_count(round_count4)
  );

  chacha_quarter_round u_qr_unit (
    .a_i(qa), .b_i(qb), .c_i(qc), .d_i(qd), .a_o(ra), .b_o(rb), .c_o(rc), .d_o(rd)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  task automatic mqr(input int a, input int b, input int c, input int d);
    mdl_w[a] = mdl_w[a] + mdl_w[b]; mdl_w[d] = rl(mdl_w[d] ^ mdl_w[a], 16);
    mdl_w[c] = mdl_w[c] + mdl_w[d]; mdl_w[b] = rl(mdl_w[b] ^ mdl_w[c], 12);
    mdl_w[a] = mdl_w[a] + mdl_w[b]; mdl_w[d] = rl(mdl_w[d] ^ mdl_w[a], 8);
    mdl_w[c] = mdl_w[c] + mdl_w[d]; mdl_w[b] = rl(mdl_w[b] ^ mdl_w[c], 7);
  endtask

  // Reference ChaCha20 block on the bench's copy of the input state; bumps the counter afterwards.
  task automatic model_block();
    mdl_w = shadow;
    for (int r = 0; r < 10; r++) begin
      mqr(0, 4, 8, 12); mqr(1, 5, 9, 13); mqr(2, 6, 10, 14); mqr(3, 7, 11, 15);
      mqr(0, 5, 10, 15); mqr(1, 6, 11, 12); mqr(2, 7, 8, 13); mqr(3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) mdl_out[i] = mdl_w[i] + shadow[i];
    shadow[12] = shadow[12] + 32'd1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic run_block(input bit pulse_chk, input bit poke);
    int e, e4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", {31'd0, busy1}, 32'd1);
    e = 0; e4 = -1;
    while (!done1 && e < 200) begin
      @(negedge clk);
      e++;
      if (done4 && e4 < 0) e4 = e;
      if (poke && e == 10) begin
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'hdeadbeef; start = 1'b1;
      end else if (poke && e == 11) begin
        wr_en = 1'b0; start = 1'b0;
      end
    end
    check_val("done_latency", e, 32'd81);
    check_val("done_latency_qr4", e4, 32'd21);
    check_val("round_count", {24'd0, round_count1}, 32'd20);
    check_val("round_count_qr4", {24'd0, round_count4}, 32'd20);
    check_val("busy_at_done", {31'd0, busy1}, 32'd0);
    model_block();
    if (pulse_chk) begin
      @(negedge clk);
      check_val("done_pulse_width", {31'd0, done1}, 32'd0);
    end
  endtask

  task automatic read_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      check_val($sformatf("%s_w%0d", tag, i), rd_data1, mdl_out[i]);
      check_val($sformatf("%s_qr4_w%0d", tag, i), rd_data4, mdl_out[i]);
    end
  endtask

  initial begin
    int e;
    bit saw_done;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0; start = 1'b0; rd_addr = 4'd0;
    shadow = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
               32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
               32'd0, 32'd0, 32'd0, 32'd0};
    repeat (2) @(negedge clk);
    check_val("rst_busy", {31'd0, busy1}, 32'd0);
    check_val("rst_done", {31'd0, done1}, 32'd0);
    check_val("rst_round", {24'd0, round_count1}, 32'd0);
    check_val("rst_rd_data", rd_data1, 32'd0);
    rst_n = 1'b1;

    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    #1;
    check_val("qr_a", ra, 32'hea2a92f4);
    check_val("qr_b", rb, 32'hcb1cf8ce);
    check_val("qr_c", rc, 32'h4581472e);
    check_val("qr_d", rd, 32'h5881c4bb);
    @(negedge clk);

    // RFC 8439 block: key 00..1f, counter 1, nonce 00000009_0000004a_00000000
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b0;
      b0 = 8'(4 * i);
      write_word(4'(4 + i), {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
    end
    write_word(4'd12, 32'h00000001);
    write_word(4'd13, 32'h09000000);
    write_word(4'd14, 32'h4a000000);
    write_word(4'd15, 32'h00000000);
    run_block(1'b1, 1'b0);
    read_check("rfc");
    rd_addr = 4'd0;  @(negedge clk); check_val("rfc_const_w0", rd_data1, 32'he4e7f110);
    rd_addr = 4'd15; @(negedge clk); check_val("rfc_const_w15", rd_data1, 32'h4e3c50a2);

    // counter is now 2
    run_block(1'b1, 1'b0);
    read_check("ctr2");

    run_block(1'b1, 1'b1);
    read_check("busy_poke");

    // wrap to 0, then a second start in the done cycle
    write_word(4'd12, 32'hffffffff);
    run_block(1'b0, 1'b0);
    run_block(1'b1, 1'b0);
    read_check("b2b_wrap");

    // abort mid-run with async reset
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", {31'd0, busy1}, 32'd0);
    check_val("abort_done", {31'd0, done1}, 32'd0);
    check_val("abort_rd_data", rd_data1, 32'd0);
    check_val("abort_round", {24'd0, round_count1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (e = 0; e < 100; e++) begin
      @(negedge clk);
      if (done1) saw_done = 1'b1;
    end
    check_val("abort_no_done", {31'd0, saw_done}, 32'd0);
    check_val("abort_rd_data_hold", rd_data1, 32'd0);
    shadow = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
               32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
               32'd0, 32'd0, 32'd0, 32'd0};
    run_block(1'b1, 1'b0);
    read_check("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/chacha_block_engine.md
# chacha_block_engine

Parametrised ChaCha block-function engine and the next generation of the team's ChaCha core. It holds a 16-word input state loaded through a word write port and runs a configurable number of rounds, with one or four quarter-rounds per cycle. It then applies the feed-forward addition and exposes the 16-word keystream block on a registered read port. An optional auto-increment of the block counter (word 12) supports back-to-back keystream generation. It sits behind the top-level pin wrapper in place of the fixed-function core.

## Interface
- ROUNDS, 20: total rounds; must be even, 2..20 (8/12/20 are the supported use cases).
- QR_PER_CYCLE, 1: quarter-rounds evaluated per clock; legal values are 1 or 4.
- AUTO_INC, 1: when 1, input word 12 increments by 1 (mod 2^32) each time a block completes.
- clk  in  1  single clock; all logic rises on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  writes wr_data into input word wr_addr; ignored while busy.
- wr_addr  in  4  input-state word index 0..15.
- wr_data  in  32  input-state word value.
- start  in  1  begins a block computation when idle; ignored while busy.
- busy  out  1  high from the edge that accepts start until the edge that asserts done.
- done  out  1  single-cycle pulse; the output block is valid from this cycle.
- rd_addr  in  4  output-block word index.
- rd_data  out  32  output word at rd_addr, registered (1-cycle latency).
- round_count  out  8  number of completed rounds in the current or last run.

## Operation
- The block has three arrays: in_q[16] (input state), w[16] (working state) and out_q[16] (result).
- FSM states:
  - IDLE: RUN on start.
  - RUN: stays in RUN until the last step, then moves to FINAL.
  - FINAL: always moves to IDLE.
- On start accepted: w <= in_q, step <= 0, round_count <= 0, state <= RUN.
- One round is 4 quarter-rounds. Even rounds are column rounds (0,4,8,12 / 1,5,9,13 / 2,6,10,14 / 3,7,11,15). Odd rounds are diagonal rounds (0,5,10,15 / 1,6,11,12 / 2,7,8,13 / 3,4,9,14).
- With QR_PER_CYCLE=1, each RUN cycle applies one QR, in the order listed above. With QR_PER_CYCLE=4, each RUN cycle applies a whole round (the four QRs are independent).
- round_count increments on every cycle that completes a round.
- The quarter-round is the standard ChaCha QR: a+=b, d^=a, d<<<=16; c+=d, b^=c, b<<<=12; a+=b, d^=a, d<<<=8; c+=d, b^=c, b<<<=7. All additions are mod 2^32.
- FINAL performs three updates:
  - out_q[i] <= w[i] + in_q[i] (mod 2^32) for all i.
  - If AUTO_INC, in_q[12] <= in_q[12] + 1, wrapping 0xFFFFFFFF to 0x00000000; no carry into word 13.
  - done <= 1, busy <= 0.
- out_q holds its value until the next FINAL, and rd_data reflects out_q[rd_addr] one cycle after rd_addr is presented.
- wr_en and start in the same IDLE cycle: the write lands in in_q, but the run snapshots the pre-write in_q.
- wr_en or start while busy: dropped with no effect, and no error flag is raised.
- start in the done cycle: accepted, since the FSM is in IDLE.

## Timing
- Let N = ROUNDS*4/QR_PER_CYCLE RUN cycles. With start sampled at edge k:
  - busy is high over edges k..k+N+1.
  - done is high for one cycle after edge k+N+1.
  - Defaults (20 rounds, 1 QR/cycle): N=80, so done appears 81 edges after start. With QR_PER_CYCLE=4, N=20.
- Reset (async, any state) sets:
  - state IDLE; busy 0, done 0, round_count 0, rd_data 0.
  - w and out_q all zero.
  - in_q[0..3] = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; in_q[4..15] = 0.
- Reset mid-run aborts the run: out_q is cleared and done does not pulse.
- Combinational depth is 1 QR (or 4 parallel QRs), which is the critical path. No pipelining inside RUN.

## Structure
- Package chacha_pkg holds:
  - SIGMA constant words.
  - Column and diagonal index tables (4x4 word indices).
  - FSM state enum {IDLE, RUN, FINAL}.
  - Legality checks for ROUNDS and QR_PER_CYCLE.
- Sub-module chacha_quarter_round is purely combinational (4x32 in, 4x32 out). It is instantiated QR_PER_CYCLE times. With QR_PER_CYCLE=1, muxes select its 4 operands from w using the step index.

## Test plan
- Quarter-round unit: a=0x11111111, b=0x01020304, c=0x9b8d6f43, d=0x01234567 -> 0xea2a92f4, 0xcb1cf8ce, 0x4581472e, 0x5881c4bb.
- Full block test (defaults):
  - Load the RFC 8439 §2.3.2 state: key 00..1f, counter 1, nonce 00000009_0000004a_00000000.
  - start -> done exactly 81 edges later, round_count=20, busy low.
  - out word 0 = 0xe4e7f110, word 15 = 0x4e3c50a2.
  - Read back in_q[12]: it is now 2.
- Repeat the full block test with QR_PER_CYCLE=4 -> identical output; done 21 edges after start.
- Wrap and back-to-back run:
  - Set word 12 = 0xFFFFFFFF and run -> word 12 becomes 0x00000000 and word 13 is unchanged.
  - Issue a back-to-back start in the done cycle -> accepted, and the second block uses counter 0.
- Busy-time write and start: wr_en and start pulses during RUN -> in_q and output unchanged, and the run length is unaffected.
- Async reset asserted at step 40:
  - Immediately: busy 0, done never pulses, rd_data 0.
  - in_q words 0..3 read back as the SIGMA constants on the next run's output.
